// File: rtl/up_down_counter_checker.sv
// Passive checker for the 3-bit bounce counter: predicts each value from the previously
// observed one and reports mismatches plus traffic statistics.
module up_down_counter_checker #(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             clr_stats,
    input  logic             reverse,
    input  logic [2:0]       counter,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] rev_cnt,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic [2:0]       exp_counter,
    output logic             exp_up,
    output logic [2:0]       first_err_exp,
    output logic [2:0]       first_err_obs
);

    typedef enum logic [1:0] {IDLE, TRACK, HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] rev_cnt_q, rev_cnt_d;
    logic [CNT_W-1:0] bounce_cnt_q, bounce_cnt_d;
    logic [2:0]       exp_counter_q, exp_counter_d;
    logic             exp_up_q, exp_up_d;
    logic [2:0]       first_err_exp_q, first_err_exp_d;
    logic [2:0]       first_err_obs_q, first_err_obs_d;

    logic       mismatch;
    logic       model_run;
    logic       bounce;
    logic       nxt_up;
    logic [2:0] nxt_val;

    always_comb begin
        mismatch  = chk_en && (state_q == TRACK) && (counter != exp_counter_q);
        model_run = (state_q != HALT);

        // Direction priority: reverse request beats a boundary turnaround.
        bounce = 1'b0;
        nxt_up = exp_up_q;
        if (reverse) begin
            nxt_up = ~exp_up_q;
        end else if (exp_up_q && counter == 3'd7) begin
            nxt_up = 1'b0;
            bounce = 1'b1;
        end else if (!exp_up_q && counter == 3'd0) begin
            nxt_up = 1'b1;
            bounce = 1'b1;
        end

        if ((exp_up_q && counter != 3'd7) || (!exp_up_q && counter == 3'd0))
            nxt_val = counter + 3'd1;
        else
            nxt_val = counter - 3'd1;

        exp_counter_d   = exp_counter_q;
        exp_up_d        = exp_up_q;
        err_d           = mismatch;
        err_sticky_d    = err_sticky_q;
        err_cnt_d       = err_cnt_q;
        rev_cnt_d       = rev_cnt_q;
        bounce_cnt_d    = bounce_cnt_q;
        first_err_exp_d = first_err_exp_q;
        first_err_obs_d = first_err_obs_q;
        state_d         = state_q;

        if (model_run) begin
            exp_counter_d = nxt_val;
            exp_up_d      = nxt_up;
        end

        if (clr_stats) begin
            err_sticky_d    = 1'b0;
            err_cnt_d       = '0;
            rev_cnt_d       = '0;
            bounce_cnt_d    = '0;
            first_err_exp_d = 3'd0;
            first_err_obs_d = 3'd0;
        end else begin
            if (mismatch) begin
                err_cnt_d    = sat_inc(err_cnt_q);
                err_sticky_d = 1'b1;
                if (!err_sticky_q) begin
                    first_err_exp_d = exp_counter_q;
                    first_err_obs_d = counter;
                end
            end
            if (model_run && reverse) rev_cnt_d = sat_inc(rev_cnt_q);
            if (model_run && bounce)  bounce_cnt_d = sat_inc(bounce_cnt_q);
        end

        case (state_q)
            IDLE:    if (chk_en) state_d = TRACK;
            TRACK: begin
                if (mismatch && STOP_ON_ERR) state_d = HALT;
                else if (!chk_en)            state_d = IDLE;
            end
            HALT:    if (clr_stats) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            err_q           <= 1'b0;
            err_sticky_q    <= 1'b0;
            err_cnt_q       <= '0;
            rev_cnt_q       <= '0;
            bounce_cnt_q    <= '0;
            exp_counter_q   <= 3'd0;
            exp_up_q        <= 1'b1;
            first_err_exp_q <= 3'd0;
            first_err_obs_q <= 3'd0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            err_sticky_q    <= err_sticky_d;
            err_cnt_q       <= err_cnt_d;
            rev_cnt_q       <= rev_cnt_d;
            bounce_cnt_q    <= bounce_cnt_d;
            exp_counter_q   <= exp_counter_d;
            exp_up_q        <= exp_up_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_obs_q <= first_err_obs_d;
        end
    end

    assign err           = err_q;
    assign err_sticky    = err_sticky_q;
    assign err_cnt       = err_cnt_q;
    assign rev_cnt       = rev_cnt_q;
    assign bounce_cnt    = bounce_cnt_q;
    assign exp_counter   = exp_counter_q;
    assign exp_up        = exp_up_q;
    assign first_err_exp = first_err_exp_q;
    assign first_err_obs = first_err_obs_q;

endmodule

// File: tb/tb_up_down_counter_checker.sv
// Bench for up_down_counter_checker: a free-running bounce counter drives two checkers
// (non-stopping narrow counters, and stop-on-error) whose outputs are compared to a reference model.
module tb_up_down_counter_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, chk_en, clr_stats, reverse;
    logic [2:0] counter;

    logic        err_a, sticky_a, up_a;
    logic [3:0]  errc_a, revc_a, bnc_a;
    logic [2:0]  exp_a, fe_a, fo_a;
    logic        err_b, sticky_b, up_b;
    logic [15:0] errc_b, revc_b, bnc_b;
    logic [2:0]  exp_b, fe_b, fo_b;

    up_down_counter_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_stats(clr_stats),
        .reverse(reverse), .counter(counter),
        .err(err_a), .err_sticky(sticky_a), .err_cnt(errc_a), .rev_cnt(revc_a),
        .bounce_cnt(bnc_a), .exp_counter(exp_a), .exp_up(up_a),
        .first_err_exp(fe_a), .first_err_obs(fo_a)
    );

    up_down_counter_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_stats(clr_stats),
        .reverse(reverse), .counter(counter),
        .err(err_b), .err_sticky(sticky_b), .err_cnt(errc_b), .rev_cnt(revc_b),
        .bounce_cnt(bnc_b), .exp_counter(exp_b), .exp_up(up_b),
        .first_err_exp(fe_b), .first_err_obs(fo_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Stimulus counter position/direction, and the reference model (index 0 = dut_a, 1 = dut_b).
    int cv, cup;
    int m_exp[2], m_up[2], m_err[2], m_sticky[2], m_errc[2], m_revc[2], m_bnc[2];
    int m_fe[2], m_fo[2], m_halted[2], m_tracking[2];
    int maxv[2] = '{15, 65535};
    int stop[2] = '{0, 1};

    function automatic int nextPos(input int c, input int u);
        if ((u == 1 && c != 7) || (u == 0 && c == 0)) return (c + 1) % 8;
        return (c + 7) % 8;
    endfunction

    function automatic int nextDir(input int c, input int u, input bit r);
        if (r) return 1 - u;
        if (c == 7) return 0;
        if (c == 0) return 1;
        return u;
    endfunction

    function automatic int satInc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_exp[i] = 0; m_up[i] = 1; m_err[i] = 0; m_sticky[i] = 0;
            m_errc[i] = 0; m_revc[i] = 0; m_bnc[i] = 0; m_fe[i] = 0; m_fo[i] = 0;
            m_halted[i] = 0; m_tracking[i] = 0;
        end
    endtask

    task automatic modelStep(input bit rstn, input bit chk, input bit clr, input bit r, input int c);
        if (!rstn) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            bit mism, active, bnc;
            int nu;
            mism   = chk && m_tracking[i] == 1 && c != m_exp[i];
            active = (m_halted[i] == 0);
            nu     = nextDir(c, m_up[i], r);
            bnc    = !r && (nu != m_up[i]);
            m_err[i] = mism;
            if (clr) begin
                m_errc[i] = 0; m_revc[i] = 0; m_bnc[i] = 0; m_sticky[i] = 0; m_fe[i] = 0; m_fo[i] = 0;
            end else begin
                if (mism) begin
                    m_errc[i] = satInc(m_errc[i], maxv[i]);
                    if (m_sticky[i] == 0) begin
                        m_fe[i] = m_exp[i];
                        m_fo[i] = c;
                    end
                    m_sticky[i] = 1;
                end
                if (active && r)   m_revc[i] = satInc(m_revc[i], maxv[i]);
                if (active && bnc) m_bnc[i]  = satInc(m_bnc[i], maxv[i]);
            end
            if (active) begin
                m_exp[i] = nextPos(c, m_up[i]);
                m_up[i]  = nu;
            end
            if (m_halted[i] == 1) begin
                if (clr) m_halted[i] = 0;
            end else if (m_tracking[i] == 1) begin
                if (mism && stop[i] == 1) begin
                    m_halted[i] = 1; m_tracking[i] = 0;
                end else if (!chk) begin
                    m_tracking[i] = 0;
                end
            end else if (chk) begin
                m_tracking[i] = 1;
            end
        end
    endtask

    task automatic counterStep(input bit rstn, input bit r);
        int nu;
        if (!rstn) begin
            cv = 0; cup = 1;
            return;
        end
        nu  = nextDir(cv, cup, r);
        cv  = nextPos(cv, cup);
        cup = nu;
    endtask

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        compare("A.err", 32'(err_a), m_err[0]);
        compare("A.err_sticky", 32'(sticky_a), m_sticky[0]);
        compare("A.err_cnt", 32'(errc_a), m_errc[0]);
        compare("A.rev_cnt", 32'(revc_a), m_revc[0]);
        compare("A.bounce_cnt", 32'(bnc_a), m_bnc[0]);
        compare("A.exp_counter", 32'(exp_a), m_exp[0]);
        compare("A.exp_up", 32'(up_a), m_up[0]);
        compare("A.first_err_exp", 32'(fe_a), m_fe[0]);
        compare("A.first_err_obs", 32'(fo_a), m_fo[0]);
        compare("B.err", 32'(err_b), m_err[1]);
        compare("B.err_sticky", 32'(sticky_b), m_sticky[1]);
        compare("B.err_cnt", 32'(errc_b), m_errc[1]);
        compare("B.rev_cnt", 32'(revc_b), m_revc[1]);
        compare("B.bounce_cnt", 32'(bnc_b), m_bnc[1]);
        compare("B.exp_counter", 32'(exp_b), m_exp[1]);
        compare("B.exp_up", 32'(up_b), m_up[1]);
        compare("B.first_err_exp", 32'(fe_b), m_fe[1]);
        compare("B.first_err_obs", 32'(fo_b), m_fo[1]);
    endtask

    // One clock: inject (when inject >= 0 the counter jumps there), apply, then check.
    task automatic applyStimulus(input bit rstn, input bit chk, input bit clr, input bit r, input int inject);
        @(negedge clk);
        if (inject >= 0) cv = inject;
        rst_n = rstn; chk_en = chk; clr_stats = clr; reverse = r; counter = 3'(cv);
        @(posedge clk);
        #1;
        modelStep(rstn, chk, clr, r, cv);
        counterStep(rstn, r);
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0; chk_en = 1'b0; clr_stats = 1'b0; reverse = 1'b0; counter = 3'd0;
        cv = 0; cup = 1;
        modelReset();
        repeat (2) applyStimulus(0, 0, 0, 0, -1);

        repeat (16) applyStimulus(1, 1, 0, 0, -1);
        compare("free_run.bounce_cnt", 32'(bnc_a), 2);

        for (int k = 0; k < 20 && !(cv == 3 && cup == 1); k++) applyStimulus(1, 1, 0, 0, -1);
        applyStimulus(1, 1, 0, 1, -1);
        compare("rev_at_3.exp_up", 32'(up_a), 0);
        repeat (3) applyStimulus(1, 1, 0, 0, -1);

        for (int k = 0; k < 20 && !(cv == 7 && cup == 1); k++) applyStimulus(1, 1, 0, 0, -1);
        applyStimulus(1, 1, 0, 1, -1);
        compare("rev_at_7.exp_counter", 32'(exp_a), 6);
        repeat (3) applyStimulus(1, 1, 0, 0, -1);

        for (int k = 0; k < 20 && cv != 2; k++) applyStimulus(1, 1, 0, 0, -1);
        applyStimulus(1, 1, 0, 0, 5);
        compare("fault.first_err_obs", 32'(fo_a), 5);
        repeat (3) applyStimulus(1, 1, 0, 0, -1);
        applyStimulus(1, 1, 1, 0, -1);
        repeat (4) applyStimulus(1, 1, 0, 0, -1);

        applyStimulus(1, 1, 0, 0, (cv + 3) % 8);
        applyStimulus(1, 1, 0, 0, -1);
        applyStimulus(1, 1, 0, 0, (cv + 3) % 8);
        repeat (2) applyStimulus(1, 1, 0, 0, -1);
        compare("halt.err_cnt", 32'(errc_b), 1);
        applyStimulus(1, 1, 1, 0, -1);
        repeat (4) applyStimulus(1, 1, 0, 0, -1);

        repeat (25) applyStimulus(1, 1, 0, 0, (cv + 1) % 8);
        repeat (20) applyStimulus(1, 1, 0, 1, -1);

        repeat (300) begin
            bit r, chk, clr;
            int inj;
            r   = ($urandom_range(0, 5) == 0);
            chk = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 39) == 0);
            inj = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            applyStimulus(1, chk, clr, r, inj);
        end

        applyStimulus(1, 1, 0, 0, (cv + 2) % 8);
        applyStimulus(0, 1, 0, 0, -1);
        repeat (5) applyStimulus(1, 1, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/up_down_counter_checker.md
# up_down_counter_checker

Passive cycle-accurate checker on the up/down counter's interface. It samples the same `reverse` stimulus and `counter[2:0]` output the counter sees and drives, and runs an internal model of the bounce-counter rules. Each cycle it compares the observed value against the prediction and reports mismatches plus traffic statistics. It sits beside the counter in the verification top as the observing end of its interface, and drives nothing back into the DUT.

## Interface
- `CNT_W`, default 16: width of each saturating statistics counter.
- `STOP_ON_ERR`, default 0: when 1, the first mismatch freezes all statistics and the model until `clr_stats`.
- `clk`  in  1: single clock, shared with the counter.
- `rst_n`  in  1: reset is synchronous and active-low.
- `chk_en`  in  1: enables comparison and error reporting; the model still tracks while this is low.
- `clr_stats`  in  1: synchronous clear of statistics, sticky flag and captured values.
- `reverse`  in  1: observed copy of the counter's `reverse` input.
- `counter`  in  3: observed counter output.
- `err`  out  1: registered one-cycle pulse per mismatch.
- `err_sticky`  out  1: set by any mismatch; held until reset or `clr_stats`.
- `err_cnt`  out  CNT_W: mismatch count, saturating.
- `rev_cnt`  out  CNT_W: number of cycles with `reverse`=1, saturating.
- `bounce_cnt`  out  CNT_W: number of boundary turnarounds not caused by `reverse`, saturating.
- `exp_counter`  out  3: model's prediction for the current cycle.
- `exp_up`  out  1: model direction; 1 means up.
- `first_err_exp`, `first_err_obs`  out  3 each: expected and observed values at the first mismatch.

## Operation
- Model registers: `exp_counter` and `exp_up`. The model is updated every cycle in TRACK and IDLE, using the OBSERVED `counter` (c), `exp_up` (u) and `reverse` (r).
- Next direction, evaluated in priority order:
  - r=1: ~u.
  - u=1 and c=7: 0, counted as a bounce.
  - u=0 and c=0: 1, counted as a bounce.
  - otherwise: u.
- Next value: if (u and c≠7) or (u=0 and c=0), then c+1; else c−1. Both are 3-bit modulo. The value update uses the current u, not the next direction.
- Because the model is seeded from the observed c, it self-resynchronises one cycle after any mismatch.
- Mismatch condition: `chk_en`=1, state TRACK, and `counter`≠`exp_counter`.
- FSM states:
  - IDLE: entered on reset. Moves to TRACK on the first cycle with `chk_en`=1.
  - TRACK: comparing. Moves to HALT on a mismatch only when STOP_ON_ERR=1. Returns to IDLE when `chk_en`=0.
  - HALT: `err` held low, statistics and model frozen. Moves to IDLE on `clr_stats`.
- On the first mismatch since the last clear: capture `first_err_exp` and `first_err_obs`.
- Every statistics counter saturates at 2^CNT_W−1 and never wraps.
- `clr_stats` zeroes `err_cnt`, `rev_cnt`, `bounce_cnt`, `err_sticky`, `first_err_*`, and re-arms first-error capture. It takes priority over any same-cycle increment. The model is not touched by `clr_stats`.

## Timing
- Reset values: `exp_counter`=0, `exp_up`=1, `err`=0, `err_sticky`=0, all counts 0, `first_err_*`=0, state IDLE.
- Reset mid-operation returns every output to its reset value on the next edge.
- After reset release, the counter's first value (0) is compared against `exp_counter`=0 and must pass.
- `err` is asserted in cycle n+1 for a mismatch seen in cycle n. `err_cnt` and `err_sticky` update on the same edge.
- `exp_counter` changes each edge and is valid for comparison in the following cycle.
- Simultaneous reverse and boundary (r=1 with u=1, c=7): the direction flips via the reverse rule. `rev_cnt` increments and `bounce_cnt` does not.
- Cases r=1 with u=0, c=0, and r=1 with u=1, c=7 must match the rules above exactly:
  - r=1, u=0, c=0: next value 1, next direction up.
  - r=1, u=1, c=7: next value 6, next direction down.

## Test plan
- Free-running counter, `chk_en`=1, no reverse for 16 cycles.
  - Observed sequence: 0,1,…,7,6,…,0,1.
  - Required: `err` never asserts and `bounce_cnt`=2.
- `reverse` pulsed while counting up at `counter`=3.
  - Next observed value is 4, then 3, 2.
  - Required: no error, `exp_up`=0, `rev_cnt`=1.
- `reverse` pulsed at `counter`=7 going up.
  - Next value is 6, direction down.
  - Required: no error, `rev_cnt`=1, `bounce_cnt` unchanged.
- Force `counter`=5 when 2 is expected.
  - Required: `err` pulses exactly one cycle later, `err_cnt`=1, `first_err_exp`=2, `first_err_obs`=5.
  - Required: the next cycle's prediction follows from 5 with no further errors.
- STOP_ON_ERR=1 with two injected faults.
  - Required: `err_cnt`=1 and state HALT.
  - Then `clr_stats`=1: all statistics return to 0 and checking resumes through IDLE→TRACK.
- Assert `rst_n`=0 mid-run with non-zero statistics.
  - Required: all outputs return to their reset values on the next edge, and the first post-reset sample (0) passes.
